pool_window_sequencer: RTL and testbench



---
 rtl/pool_pkg.sv | 20 ++
 rtl/qadd.sv | 32 +++
 rtl/pool_window_sequencer.sv | 157 +++++++++++++++
 tb/tb_pool_window_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the sum-pooling window sequencer.
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT,
    DONE
  } state_e;

  localparam int DEF_N = 32;
  localparam int DEF_Q = 16;

  // Number of output tiles for a map walked in non-overlapping windows.
  function automatic int tiles(input int img_w, input int img_h, input int window);
    return (img_w / window) * (img_h / window);
  endfunction

endpackage

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder (MSB is sign, N-1 magnitude bits, Q fractional).
// No saturation: magnitude overflow wraps.
module qadd #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  if (Q >= N) begin : g_bad_q
    $error("qadd: Q must be smaller than N");
  end

  always_comb begin
    // NOTE: default every output of an always_comb first so no path can infer a latch.
    c = '0;
    if (a[N-1] == b[N-1]) begin
      c[N-2:0] = a[N-2:0] + b[N-2:0];
      c[N-1]   = a[N-1];
    end else if (a[N-2:0] > b[N-2:0]) begin
      c[N-2:0] = a[N-2:0] - b[N-2:0];
      c[N-1]   = a[N-1];
    end else begin
      // A zero difference is always reported as +0.
      c[N-2:0] = b[N-2:0] - a[N-2:0];
      c[N-1]   = b[N-1] && (b[N-2:0] != a[N-2:0]);
    end
  end

endmodule

// File: rtl/pool_window_sequencer.sv
// Walks a row-major feature map in WINDOW x WINDOW tiles, one buffer read per cycle,
// accumulating each tile through a single shared qadd and emitting it on valid/ready.
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int Q      = DEF_Q,
  parameter int WINDOW = 4,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [IDX_W-1:0]  out_index
);

  localparam int TC    = IMG_W / WINDOW;
  localparam int TR    = IMG_H / WINDOW;
  localparam int KN    = WINDOW * WINDOW;
  localparam int TILES = tiles(IMG_W, IMG_H, WINDOW);
  localparam int OC_W  = (TC > 1) ? $clog2(TC) : 1;
  localparam int OR_W  = (TR > 1) ? $clog2(TR) : 1;
  localparam int K_W   = (KN > 1) ? $clog2(KN) : 1;

  if (TILES > (1 << IDX_W) || IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_widths
    $error("pool_window_sequencer: IDX_W or ADDR_W too narrow for the map");
  end

  state_e            state_q;
  logic [OR_W-1:0]   orow_q;
  logic [OC_W-1:0]   ocol_q;
  logic [K_W-1:0]    k_q;
  logic [N-1:0]      acc_q, acc_d, add_a, add_sum;
  logic              rd_vld_q, rd_first_q;
  logic              busy_q, done_q, rd_en_q, out_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [N-1:0]      out_data_q;
  logic [IDX_W-1:0]  out_index_q;
  logic              last_k, last_col, last_row;

  function automatic logic [ADDR_W-1:0] tile_addr(input int orow, input int ocol, input int k);
    return ADDR_W'((orow * WINDOW + k / WINDOW) * IMG_W + ocol * WINDOW + k % WINDOW);
  endfunction

  assign last_k   = (k_q == K_W'(KN - 1));
  assign last_col = (ocol_q == OC_W'(TC - 1));
  assign last_row = (orow_q == OR_W'(TR - 1));

  // The first element of a tile restarts the sum instead of adding to the old one.
  assign add_a = rd_first_q ? '0 : acc_q;
  assign acc_d = rd_vld_q ? add_sum : acc_q;

  qadd #(.Q(Q), .N(N)) u_acc_add (
    .a(add_a),
    .b(rd_data),
    .c(add_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      orow_q      <= '0;
      ocol_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      // Read data lands one cycle after its strobe.
      rd_vld_q   <= rd_en_q;
      rd_first_q <= rd_en_q && (k_q == '0);
      acc_q      <= acc_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= tile_addr(0, 0, 0);
            orow_q    <= '0;
            ocol_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
          end
        end
        FETCH: begin
          if (last_k) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            k_q       <= k_q + 1'b1;
            rd_addr_q <= tile_addr(int'(orow_q), int'(ocol_q), int'(k_q) + 1);
          end
        end
        DRAIN: begin
          state_q     <= EMIT;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_d;
          out_index_q <= IDX_W'(int'(orow_q) * TC + int'(ocol_q));
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_col && last_row) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              rd_en_q <= 1'b1;
              k_q     <= '0;
              if (last_col) begin
                ocol_q    <= '0;
                orow_q    <= orow_q + 1'b1;
                rd_addr_q <= tile_addr(int'(orow_q) + 1, 0, 0);
              end else begin
                ocol_q    <= ocol_q + 1'b1;
                rd_addr_q <= tile_addr(int'(orow_q), int'(ocol_q) + 1, 0);
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Scoreboard bench for pool_window_sequencer: a behavioural buffer feeds reads,
// expected tile sums are queued at start and compared on every accepted output.
module tb_pool_window_sequencer;

  localparam int N      = 32;
  localparam int WINDOW = 4;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 8;
  localparam int IDX_W  = 4;
  localparam int TC     = IMG_W / WINDOW;
  localparam int KN     = WINDOW * WINDOW;
  localparam int TILES  = TC * (IMG_H / WINDOW);
  localparam int NPIX   = IMG_W * IMG_H;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic              busy, done, rd_en, out_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      rd_data;
  logic [N-1:0]      out_data;
  logic [IDX_W-1:0]  out_index;

  logic [N-1:0] mem [NPIX];
  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           rd_count = 0;
  int           done_count = 0;

  always #5 clk = ~clk;

  pool_window_sequencer #(
    .N(N), .Q(16), .WINDOW(WINDOW), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  // Buffer model: data for a strobed address is valid through the following cycle.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference sum in plain signed arithmetic, converted back to sign-magnitude.
  function automatic logic [N-1:0] model_tile(input int t);
    longint s;
    int orow, ocol;
    s    = 0;
    orow = t / TC;
    ocol = t % TC;
    for (int r = 0; r < WINDOW; r++) begin
      for (int c = 0; c < WINDOW; c++) begin
        logic [N-1:0] v;
        v = mem[(orow * WINDOW + r) * IMG_W + ocol * WINDOW + c];
        s += v[N-1] ? -longint'(v[N-2:0]) : longint'(v[N-2:0]);
      end
    end
    return (s < 0) ? {1'b1, (N-1)'(-s)} : {1'b0, (N-1)'(s)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_en) rd_count++;
      if (done) done_count++;
      if (out_valid && out_ready) begin
        check("sb_empty_on_output", sb_q.size() == 0, 0);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_index", out_index, e.idx);
          check("out_data", out_data, e.data);
        end
      end
    end
  end

  task automatic fill_const(input logic [N-1:0] v);
    for (int a = 0; a < NPIX; a++) mem[a] = v;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < NPIX; a++) mem[a] = N'(a) << 16;
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_busy"}, busy, 0);
    check({where, "_done"}, done, 0);
    check({where, "_rd_en"}, rd_en, 0);
    check({where, "_rd_addr"}, rd_addr, 0);
    check({where, "_out_valid"}, out_valid, 0);
    check({where, "_out_data"}, out_data, 0);
    check({where, "_out_index"}, out_index, 0);
  endtask

  task automatic start_pass();
    rd_count   = 0;
    done_count = 0;
    for (int t = 0; t < TILES; t++) sb_q.push_back({IDX_W'(t), model_tile(t)});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is seen (+#1), i.e. still inside the done cycle.
  task automatic run_pass(input int stall_tile, input bit poke_busy, input bit check_lat);
    start_pass();
    fork
      begin : main_wait
        int n;
        int g;
        if (check_lat) begin
          n = 1;
          @(negedge clk);
          while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
          end
          check("first_valid_latency", n, KN + 2);
        end
        g = 0;
        while (!done && g < 4000) begin
          @(negedge clk);
          g++;
        end
        check("done_seen", done, 1);
      end
      begin : stall_ctl
        if (stall_tile >= 0) begin
          int g;
          int nt;
          logic [N-1:0] exp_d;
          g = 0;
          while (!(out_valid && out_ready && out_index == IDX_W'(stall_tile - 1)) && g < 2000) begin
            @(negedge clk);
            g++;
          end
          @(posedge clk); #1 out_ready = 1'b0;
          @(negedge clk);
          g = 0;
          while (!out_valid && g < 200) begin
            @(negedge clk);
            g++;
          end
          exp_d = model_tile(stall_tile);
          for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_rd_en", rd_en, 0);
            check("stall_out_index", out_index, stall_tile);
            check("stall_out_data", out_data, exp_d);
          end
          @(posedge clk); #1 out_ready = 1'b1;
          @(negedge clk);
          @(negedge clk);
          nt = stall_tile + 1;
          check("resume_rd_en", rd_en, 1);
          check("resume_rd_addr", rd_addr, (nt / TC) * WINDOW * IMG_W + (nt % TC) * WINDOW);
        end
      end
      begin : poke_ctl
        if (poke_busy) begin
          repeat (30) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
          check("busy_during_poke", busy, 1);
        end
      end
    join
    #1;
    check("reads_per_pass", rd_count, NPIX);
    check("done_pulses", done_count, 1);
    check("busy_in_done", busy, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fill_const(32'h0001_0000);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // All 1.0: every tile sums to 16.0; also checks first-output latency.
    run_pass(-1, 1'b0, 1'b1);
    @(negedge clk);
    check("done_width", done, 0);
    check("idle_busy", busy, 0);

    // Ramp data; the next pass starts the cycle right after done.
    fill_ramp();
    run_pass(-1, 1'b0, 1'b0);
    run_pass(3, 1'b0, 1'b0);

    // Mixed signs: tile 5 holds fifteen 2.0 and one -0.5, tile 9 is all -1.0.
    fill_const(32'h0001_0000);
    for (int k = 0; k < KN; k++) begin
      mem[(WINDOW + k / WINDOW) * IMG_W + WINDOW + k % WINDOW] = (k == 6) ? 32'h8000_8000 : 32'h0002_0000;
      mem[(2 * WINDOW + k / WINDOW) * IMG_W + WINDOW + k % WINDOW] = 32'h8001_0000;
    end
    run_pass(-1, 1'b1, 1'b0);
    // start during the done cycle must not restart the pass.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_restart_busy", busy, 0);
      check("no_restart_rd_en", rd_en, 0);
    end

    // Reset in the middle of tile 2, then a clean pass.
    fill_ramp();
    start_pass();
    begin
      int g;
      g = 0;
      while (!(rd_en && rd_addr == ADDR_W'(2 * WINDOW + 2)) && g < 500) begin
        @(negedge clk);
        g++;
      end
      check("reached_tile2", rd_en && rd_addr == ADDR_W'(2 * WINDOW + 2), 1);
    end
    reset = 1'b1;
    @(posedge clk); #1 check_reset_outputs("midreset");
    @(negedge clk) reset = 1'b0;
    sb_q.delete();
    run_pass(-1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
